sync_req_ack_rx: RTL and testbench
==================================

// Module: sync_req_ack_rx
// PURPOSE
//   Destination-side 4-phase handshake receiver for clock-domain crossings.
//   Consumes the level-synchronised request (output of a sync_level2level stage).
//   Captures the quasi-static source data bus and presents it as a valid/ready transfer.
//   Drives an ack level back to the source domain through its own synchroniser.
//   Adds a programmable stability filter on the synchronised request.
// PARAMETERS
//   DATA_WIDTH  32  width of req_data / out_data
//   FILT_CNT    2   consecutive cycles req_sync must hold a level before it is accepted (>=1)
// PORTS
//   clk        in   1           destination-domain clock
//   rst        in   1           synchronous reset, active-high
//   req_sync   in   1           synchronised request level from source
//   req_data   in   DATA_WIDTH  source data; stable while request is high
//   out_vld    out  1           captured data valid toward consumer
//   out_rdy    in   1           consumer accepts out_data
//   out_data   out  DATA_WIDTH  captured data; held while out_vld=1
//   ack_out    out  1           ack level to source domain (registered, glitch-free)
//   busy       out  1           state != IDLE
//   proto_err  out  1           sticky: request dropped before transfer completed
// BEHAVIOUR
//   - Reset (rst=1 at posedge):
//     - state=IDLE; out_vld=0, ack_out=0, busy=0, proto_err=0, out_data=0, filter count=0.
//     - Reset overrides everything, including mid-handshake; the source must be reset
//       with this block.
//   - Filter counter, width $clog2(FILT_CNT+1):
//     - Counts consecutive cycles in which req_sync equals the target level
//       (IDLE target=1, ACK target=0).
//     - Cleared on any mismatch and on every state change.
//     - A level is accepted at the posedge where req_sync==target and count==FILT_CNT-1.
//   - IDLE:
//     - On acceptance of req_sync=1: out_data<=req_data, state->VALID.
//     - req_data is sampled only at that edge.
//   - VALID:
//     - out_vld=1; out_data stable.
//     - At a posedge with out_rdy=1, the transfer completes: state->ACK; out_vld=0 next cycle.
//     - out_rdy is ignored in all other states.
//     - If req_sync==0 in any VALID cycle, proto_err<=1. The transfer still completes normally.
//   - ACK:
//     - ack_out=1 (registered; rises on the edge entering ACK).
//     - On acceptance of req_sync=0: state->IDLE; ack_out falls on that edge.
//   - Latency:
//     - req_sync rise sampled at posedge k -> out_vld=1 after posedge k+FILT_CNT-1.
//     - Transfer at posedge t -> ack_out=1 after posedge t.
//     - req_sync fall sampled at posedge m -> ack_out=0 after posedge m+FILT_CNT-1.
//   - Back-to-back requests: a new rise is counted only after IDLE is re-entered;
//     no transfer is lost or duplicated.
//   - Glitches: a req_sync pulse shorter than FILT_CNT cycles in IDLE (or a low pulse
//     in ACK) is ignored. The counter restarts.
//   - proto_err is cleared only by rst.
//   - No combinational path from any input to any output.
//   - busy = (state!=IDLE).
//   - State encoding: IDLE=2'd0, VALID=2'd1, ACK=2'd2.
//     - 2'd3 is illegal; it recovers to IDLE with ack_out=0 and out_vld=0.
// TESTING
//   1. Basic: FILT_CNT=2, out_rdy=1.
//      - req_sync 0->1 with req_data=32'hA5A5_0001.
//      - out_vld high 2 cycles after the rise; out_data=A5A50001; ack_out rises next cycle.
//      - Drop req -> ack_out low 2 cycles later; busy=0.
//   2. Backpressure:
//      - Hold out_rdy=0 for 10 cycles -> out_vld and out_data stay stable; ack_out stays 0.
//      - Assert out_rdy -> exactly one transfer.
//   3. Glitch filter: FILT_CNT=3.
//      - A 2-cycle req_sync high pulse -> no out_vld; state stays IDLE.
//      - A 3-cycle pulse -> one capture.
//   4. Protocol error:
//      - Drop req_sync while out_vld=1 and out_rdy=0 -> proto_err=1 (sticky).
//      - The transfer still completes once out_rdy=1.
//   5. Reset mid-op: assert rst during ACK -> next cycle ack_out=0, out_vld=0, busy=0, proto_err=0.
//   6. Streaming: 100 random-data requests against a source-domain model with random
//      out_rdy -> data in order, no drops or duplicates, ack toggles exactly 100 times.

Source files
------------

// File: rtl/sync_req_ack_rx.sv
// Destination side of a 4-phase req/ack CDC handshake. It filters the synchronised
// request, captures the source data once per request, and offers it as a valid/ready beat.
module sync_req_ack_rx #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FILT_CNT   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_sync,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  ack_out,
    output logic                  busy,
    output logic                  proto_err
);

    localparam int unsigned CW = $clog2(FILT_CNT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        ACK   = 2'd2,
        BAD   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  perr_d;

    // Next-state: the filter counter resets to zero whenever it is not explicitly advanced,
    // which covers both a level mismatch and every state change.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        data_d  = out_data;
        perr_d  = proto_err;
        case (state_q)
            IDLE: begin
                if (req_sync) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = VALID;
                        data_d  = req_data;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            VALID: begin
                if (!req_sync) begin
                    perr_d = 1'b1;
                end
                if (out_rdy) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!req_sync) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The outputs are registered from the next state, so each one changes on the edge that enters or leaves its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            out_data  <= '0;
            proto_err <= 1'b0;
            out_vld   <= 1'b0;
            ack_out   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_data  <= data_d;
            proto_err <= perr_d;
            out_vld   <= (state_d == VALID);
            ack_out   <= (state_d == ACK);
            busy      <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_sync_req_ack_rx.sv
// Directed and streaming bench for sync_req_ack_rx. A queue holds each request's data,
// and every valid/ready beat is checked against the front of that queue.
module tb_sync_req_ack_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_sync, req_sync3;
    logic [31:0] req_data;
    logic        out_rdy, out_rdy3;
    logic        out_vld, out_vld3;
    logic [31:0] out_data, out_data3;
    logic        ack_out, ack_out3;
    logic        busy, busy3;
    logic        proto_err, proto_err3;

    int          checks = 0;
    int          errors = 0;
    int          xfers = 0;
    int          ack_rises = 0;
    int          cap3 = 0;
    logic        ack_prev = 1'b0;
    logic        vld3_prev = 1'b0;
    bit          rand_rdy = 1'b0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    sync_req_ack_rx #(.DATA_WIDTH(32), .FILT_CNT(2)) dut (
        .clk(clk), .rst(rst), .req_sync(req_sync), .req_data(req_data),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
        .ack_out(ack_out), .busy(busy), .proto_err(proto_err)
    );

    sync_req_ack_rx #(.DATA_WIDTH(32), .FILT_CNT(3)) dut3 (
        .clk(clk), .rst(rst), .req_sync(req_sync3), .req_data(req_data),
        .out_vld(out_vld3), .out_rdy(out_rdy3), .out_data(out_data3),
        .ack_out(ack_out3), .busy(busy3), .proto_err(proto_err3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge. Outputs are read there or on the falling edge.
    task automatic step();
        @(posedge clk);
        #2;
        if (rand_rdy) out_rdy = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_ack(input logic lvl);
        int n = 0;
        while (ack_out !== lvl && n < 200) begin
            step();
            n++;
        end
        chk(lvl ? "ack_rise_timeout" : "ack_fall_timeout", 32'(ack_out), 32'(lvl));
    endtask

    task automatic do_req(input logic [31:0] d);
        sb.push_back(d);
        req_data = d;
        req_sync = 1'b1;
        wait_ack(1'b1);
        req_sync = 1'b0;
        wait_ack(1'b0);
    endtask

    // Consumer-side monitor: a beat with out_vld and out_rdy both high is taken at the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_vld && out_rdy) begin
                chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) chk("sb_data", out_data, sb.pop_front());
                xfers++;
            end
            if (ack_out && !ack_prev) ack_rises++;
            if (out_vld3 && !vld3_prev) cap3++;
        end
        ack_prev  = ack_out;
        vld3_prev = out_vld3;
    end

    initial begin
        int x0, a0;
        rst = 1'b1; req_sync = 1'b0; req_sync3 = 1'b0; req_data = '0;
        out_rdy = 1'b1; out_rdy3 = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst_vld", 32'(out_vld), 0);
        chk("rst_ack", 32'(ack_out), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_perr", 32'(proto_err), 0);
        chk("rst_data", out_data, 0);

        // 1. basic handshake
        req_data = 32'hA5A5_0001; req_sync = 1'b1; sb.push_back(req_data);
        step();
        chk("b_vld_early", 32'(out_vld), 0);
        step();
        chk("b_vld", 32'(out_vld), 1);
        chk("b_data", out_data, 32'hA5A5_0001);
        chk("b_busy", 32'(busy), 1);
        step();
        chk("b_ack", 32'(ack_out), 1);
        chk("b_vld_low", 32'(out_vld), 0);
        req_sync = 1'b0;
        step();
        chk("b_ack_hold", 32'(ack_out), 1);
        step();
        chk("b_ack_fall", 32'(ack_out), 0);
        chk("b_idle", 32'(busy), 0);

        // 2. backpressure
        x0 = xfers;
        out_rdy = 1'b0; req_data = 32'hA5A5_0002; req_sync = 1'b1; sb.push_back(req_data);
        step(); step();
        for (int i = 0; i < 10; i++) begin
            chk("bp_vld", 32'(out_vld), 1);
            chk("bp_data", out_data, 32'hA5A5_0002);
            chk("bp_ack", 32'(ack_out), 0);
            step();
        end
        out_rdy = 1'b1;
        step();
        chk("bp_ack", 32'(ack_out), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_no_dup", 32'(out_vld), 0);
        end
        req_sync = 1'b0;
        wait_ack(1'b0);
        chk("bp_one_xfer", 32'(xfers - x0), 1);

        // 3. glitch filter with FILT_CNT=3
        req_data = 32'h0000_3333; req_sync3 = 1'b1;
        step(); step();
        req_sync3 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("g_no_vld", 32'(out_vld3), 0);
            chk("g_idle", 32'(busy3), 0);
            step();
        end
        req_sync3 = 1'b1;
        step(); step(); step();
        req_sync3 = 1'b0;
        chk("g_vld", 32'(out_vld3), 1);
        chk("g_data", out_data3, 32'h0000_3333);
        for (int i = 0; i < 6; i++) step();
        chk("g_one_cap", 32'(cap3), 1);
        chk("g_ack_done", 32'(ack_out3), 0);
        chk("g_perr", 32'(proto_err3), 1);

        // 4. protocol error while stalled
        out_rdy = 1'b0; req_data = 32'hA5A5_0004; req_sync = 1'b1; sb.push_back(req_data);
        step(); step();
        chk("pe_vld", 32'(out_vld), 1);
        req_sync = 1'b0;
        step();
        chk("pe_set", 32'(proto_err), 1);
        step();
        chk("pe_vld_hold", 32'(out_vld), 1);
        out_rdy = 1'b1;
        step();
        chk("pe_ack", 32'(ack_out), 1);
        wait_ack(1'b0);
        chk("pe_sticky", 32'(proto_err), 1);
        chk("pe_sb_empty", 32'(sb.size()), 0);

        // 5. reset in ACK
        req_data = 32'hA5A5_0005; req_sync = 1'b1; sb.push_back(req_data);
        step(); step(); step();
        chk("r_in_ack", 32'(ack_out), 1);
        rst = 1'b1;
        step();
        chk("r_ack", 32'(ack_out), 0);
        chk("r_vld", 32'(out_vld), 0);
        chk("r_busy", 32'(busy), 0);
        chk("r_perr", 32'(proto_err), 0);
        rst = 1'b0; req_sync = 1'b0;
        step();

        // 6. streaming with random consumer stalls
        x0 = xfers; a0 = ack_rises; rand_rdy = 1'b1;
        for (int i = 0; i < 100; i++) do_req($urandom());
        rand_rdy = 1'b0;
        chk("s_xfers", 32'(xfers - x0), 100);
        chk("s_ack_toggles", 32'(ack_rises - a0), 100);
        chk("s_sb_empty", 32'(sb.size()), 0);
        chk("s_perr", 32'(proto_err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
